// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults and owner encoding for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_MAX_DATA_RUN = 3;

    // Which requester owns the read response arriving in the next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_RD   = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_run_counter.sv
// Fairness counter: counts consecutive data grants while fetch is waiting.
module mem_arb_run_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
    input  logic clk,
    input  logic reset,
    input  logic d_gnt,
    input  logic if_gnt,
    input  logic if_req,
    output logic starve
);

    localparam int CNT_W = (MAX_DATA_RUN < 1) ? 1 : $clog2(MAX_DATA_RUN + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_RUN);

    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_cnt_d;

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (if_gnt || !if_req) begin
            run_cnt_d = '0;
        end else if (d_gnt && (run_cnt_q != MAX_CNT)) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end

    assign starve = (run_cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with
// combinational grants, one-cycle read latency and a fetch starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e owner_q;
    owner_e owner_d;
    logic   starve;

    mem_arb_run_counter #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_run_counter (
        .clk   (clk),
        .reset (reset),
        .d_gnt (d_gnt),
        .if_gnt(if_gnt),
        .if_req(if_req),
        .starve(starve)
    );

    // Data wins by default; fetch takes the port once data has had its run.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (d_req && !(starve && if_req)) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            owner_d  = OWN_IF;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_we ? d_wdata : '0;
            owner_d   = d_we ? OWN_NONE : OWN_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // A response still in flight when reset arrives is discarded.
    always_comb begin
        if_rvalid = !reset && (owner_q == OWN_IF);
        d_rvalid  = !reset && (owner_q == OWN_RD);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with per-cycle protocol invariants.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    bit inv_on = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            check("inv_one_gnt", 64'(if_gnt & d_gnt), 64'd0);
            check("inv_one_rvalid", 64'(if_rvalid & d_rvalid), 64'd0);
            check("inv_mem_en", 64'(mem_en), 64'(if_gnt | d_gnt));
        end
    end

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0;
        next_cycle();
        // Requests during reset must be ignored.
        if_req = 1'b1; if_addr = 32'h77; d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h55; d_wdata = 32'hAA;
        sample();
        inv_on = 1'b1;
        check("rst_if_gnt", 64'(if_gnt), 64'd0);
        check("rst_d_gnt", 64'(d_gnt), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);

        // Fetch only, in the first cycle out of reset.
        next_cycle();
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        if_req = 1'b1; if_addr = 32'h100;
        sample();
        $display("fetch grant: if_gnt=%0b mem_addr=%0h", if_gnt, mem_addr);
        check("fetch_if_gnt", 64'(if_gnt), 64'd1);
        check("fetch_mem_en", 64'(mem_en), 64'd1);
        check("fetch_mem_addr", 64'(mem_addr), 64'h100);
        check("fetch_mem_we", 64'(mem_we), 64'd0);
        check("fetch_mem_wdata", 64'(mem_wdata), 64'd0);
        next_cycle();
        if_req = 1'b0; mem_rdata = 32'hDEADBEEF;
        sample();
        $display("fetch resp: if_rvalid=%0b if_rdata=%0h", if_rvalid, if_rdata);
        check("fetch_rvalid", 64'(if_rvalid), 64'd1);
        check("fetch_rdata", 64'(if_rdata), 64'hDEADBEEF);
        check("fetch_d_rvalid", 64'(d_rvalid), 64'd0);
        check("fetch_d_rdata", 64'(d_rdata), 64'd0);
        check("fetch_idle_en", 64'(mem_en), 64'd0);

        // Contention: three data grants, then fetch, then data again.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
            mem_rdata = 32'hA0 + 32'(k);
            sample();
            $display("contention cycle %0d: d_gnt=%0b if_gnt=%0b mem_addr=%0h", k, d_gnt, if_gnt, mem_addr);
            check("cont_d_gnt", 64'(d_gnt), (k == 3) ? 64'd0 : 64'd1);
            check("cont_if_gnt", 64'(if_gnt), (k == 3) ? 64'd1 : 64'd0);
            check("cont_addr", 64'(mem_addr), (k == 3) ? 64'h300 : 64'h200);
            if (k > 0) begin
                check("cont_if_rvalid", 64'(if_rvalid), (k == 4) ? 64'd1 : 64'd0);
                check("cont_d_rvalid", 64'(d_rvalid), (k == 4) ? 64'd0 : 64'd1);
                check("cont_d_rdata", 64'(d_rdata), (k == 4) ? 64'd0 : 64'hA0 + 64'(k));
            end
        end
        next_cycle();
        if_req = 1'b0; d_req = 1'b0; mem_rdata = 32'hB5;
        sample();
        check("cont_last_rvalid", 64'(d_rvalid), 64'd1);
        check("cont_last_rdata", 64'(d_rdata), 64'hB5);

        // Store completes at grant with no response.
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; mem_rdata = 32'hFFFF;
        sample();
        $display("store: d_gnt=%0b mem_we=%0b mem_wdata=%0h", d_gnt, mem_we, mem_wdata);
        check("st_d_gnt", 64'(d_gnt), 64'd1);
        check("st_mem_en", 64'(mem_en), 64'd1);
        check("st_mem_we", 64'(mem_we), 64'd1);
        check("st_mem_addr", 64'(mem_addr), 64'h40);
        check("st_mem_wdata", 64'(mem_wdata), 64'h12345678);
        next_cycle();
        d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        sample();
        check("st_no_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);

        // Back-to-back fetch then load.
        next_cycle();
        if_req = 1'b1; if_addr = 32'h0;
        sample();
        check("b2b_if_gnt", 64'(if_gnt), 64'd1);
        next_cycle();
        if_req = 1'b0; d_req = 1'b1; d_addr = 32'h8; mem_rdata = 32'h11111111;
        sample();
        $display("b2b cycle1: d_gnt=%0b if_rvalid=%0b if_rdata=%0h", d_gnt, if_rvalid, if_rdata);
        check("b2b_d_gnt", 64'(d_gnt), 64'd1);
        check("b2b_mem_addr", 64'(mem_addr), 64'h8);
        check("b2b_if_rvalid", 64'(if_rvalid), 64'd1);
        check("b2b_if_rdata", 64'(if_rdata), 64'h11111111);
        check("b2b_d_rdata0", 64'(d_rdata), 64'd0);
        next_cycle();
        d_req = 1'b0; mem_rdata = 32'h22222222;
        sample();
        check("b2b_d_rvalid", 64'(d_rvalid), 64'd1);
        check("b2b_d_rdata", 64'(d_rdata), 64'h22222222);
        check("b2b_if_rdata0", 64'(if_rdata), 64'd0);

        // Reset right after a fetch grant drops the response.
        next_cycle();
        if_req = 1'b1; if_addr = 32'h500;
        sample();
        check("rmid_if_gnt", 64'(if_gnt), 64'd1);
        next_cycle();
        reset = 1'b1; mem_rdata = 32'h33333333;
        sample();
        $display("reset mid-op: if_rvalid=%0b mem_en=%0b", if_rvalid, mem_en);
        check("rmid_rvalid1", 64'(if_rvalid), 64'd0);
        check("rmid_mem_en", 64'(mem_en), 64'd0);
        check("rmid_if_gnt0", 64'(if_gnt), 64'd0);
        next_cycle();
        reset = 1'b0; if_req = 1'b0;
        sample();
        check("rmid_rvalid2", 64'({if_rvalid, d_rvalid}), 64'd0);

        // Counter cleared by reset: two data grants, reset, then a full run of three.
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            reset = (k == 2);
            if_req = 1'b1; if_addr = 32'h600; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
            sample();
            $display("run reset cycle %0d: d_gnt=%0b if_gnt=%0b", k, d_gnt, if_gnt);
            check("rcnt_d_gnt", 64'(d_gnt), (k == 2 || k == 6) ? 64'd0 : 64'd1);
            check("rcnt_if_gnt", 64'(if_gnt), (k == 6) ? 64'd1 : 64'd0);
        end
        next_cycle();
        if_req = 1'b0; d_req = 1'b0;
        sample();
        inv_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; MAX_DATA_RUN, default 3, maximum consecutive data grants while fetch waits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  instruction-fetch read request; held with if_addr stable until granted.
REQ-005 if_addr  in  ADDR_W  fetch address.
REQ-006 if_gnt  out  1  fetch request accepted this cycle.
REQ-007 if_rvalid  out  1  fetch read data valid.
REQ-008 if_rdata  out  DATA_W  fetch read data.
REQ-009 d_req  in  1  load/store request; held with d_we, d_addr and d_wdata stable until granted.
REQ-010 d_we  in  1  1 = store (sw), 0 = load (lw).
REQ-011 d_addr  in  ADDR_W  data address.
REQ-012 d_wdata  in  DATA_W  store data.
REQ-013 d_gnt  out  1  data request accepted this cycle.
REQ-014 d_rvalid  out  1  load data valid; never asserted for stores.
REQ-015 d_rdata  out  DATA_W  load data.
REQ-016 mem_en  out  1  memory access strobe.
REQ-017 mem_we  out  1  memory write enable.
REQ-018 mem_addr  out  ADDR_W  memory address.
REQ-019 mem_wdata  out  DATA_W  memory write data.
REQ-020 mem_rdata  in  DATA_W  read data, valid exactly one cycle after a cycle with mem_en=1 and mem_we=0.

Function
REQ-021 At most one of if_gnt and d_gnt SHALL be 1 in any cycle; a grant SHALL be combinational in the same cycle as its request.
REQ-022 Granted cycle: mem_en=1; mem_addr, mem_we and mem_wdata SHALL be taken from the winner (mem_we=0 and mem_wdata=0 for fetch). No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 Priority: d_req SHALL win over if_req unless run_cnt==MAX_DATA_RUN and if_req=1, in which case fetch SHALL win.
REQ-024 run_cnt (width clog2(MAX_DATA_RUN+1)) SHALL increment, saturating at MAX_DATA_RUN, on each d_gnt while if_req=1; it SHALL clear on if_gnt or on any cycle with if_req=0.
REQ-025 Registered owner state SHALL have the values OWN_NONE, OWN_IF and OWN_RD. The next state SHALL be OWN_IF after if_gnt, OWN_RD after d_gnt with d_we=0, and OWN_NONE otherwise, including after a store grant.
REQ-026 Read latency SHALL be 1 cycle: when the owner is OWN_IF, if_rvalid=1 and if_rdata=mem_rdata; when it is OWN_RD, d_rvalid=1 and d_rdata=mem_rdata. The non-selected rdata SHALL be 0.
REQ-027 Back-to-back grants SHALL be supported: a new grant MAY occur in the same cycle as the response to the previous grant, giving full throughput.
REQ-028 A store SHALL complete at grant; no response cycle follows.
REQ-029 A request withdrawn before its grant SHALL be ignored; the arbiter holds no request queue.

Reset
REQ-030 While reset=1, grants SHALL be forced to 0, mem_en, mem_we, mem_addr and mem_wdata SHALL be 0, the owner SHALL be OWN_NONE and run_cnt SHALL be 0.
REQ-031 If reset is asserted in the cycle after a grant, the pending response SHALL be dropped: if_rvalid=0 and d_rvalid=0 in the reset cycle and the cycle after it.
REQ-032 Outputs SHALL be valid in the first cycle after reset deasserts, with a grant possible in that cycle.

Structure
REQ-033 A shared package SHALL hold ADDR_W, DATA_W, MAX_DATA_RUN defaults and the owner enum (OWN_NONE, OWN_IF, OWN_RD).
REQ-034 The fairness counter SHALL be one sub-module, mem_arb_run_counter, with inputs clk, reset, d_gnt, if_gnt, if_req and output starve (run_cnt==MAX_DATA_RUN).

Verification
REQ-035 Fetch only: if_req=1, if_addr=0x100, mem_rdata=0xDEADBEEF next cycle -> if_gnt=1, mem_addr=0x100, mem_we=0; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
REQ-036 Contention: if_req=1 and d_req=1 (load, 0x200) held 5 cycles -> d_gnt in cycles 0-2, if_gnt in cycle 3, d_gnt in cycle 4.
REQ-037 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_en=1, mem_we=1, mem_wdata=0x12345678; next cycle d_rvalid=0.
REQ-038 Back-to-back: fetch 0x0 then load 0x8 in consecutive cycles -> if_rvalid in cycle 1 alongside d_gnt; d_rvalid in cycle 2; d_rdata=0 in cycle 1.
REQ-039 Reset mid-operation: grant fetch in cycle 0, reset=1 in cycle 1 -> if_rvalid=0 in cycles 1-2, mem_en=0 in cycle 1, run_cnt=0.
REQ-040 Invariant checks every cycle: at most one grant, at most one rvalid, and mem_en equals if_gnt OR d_gnt.
